// File: rtl/stream_demux_pkg.sv
// Shared types for the packet stream demultiplexer: byte type and the
// per-packet routing state.
package stream_demux_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    DROP
  } demux_state_t;

endpackage

// File: rtl/stream_reg_slice.sv
// One-entry valid/ready holding register for a data byte plus last flag.
// Accepts a load on the same cycle it is being drained, so it sustains one beat per cycle.
module stream_reg_slice
  import stream_demux_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  byte_t load_data,
  input  logic  load_last,
  output logic  load_ready,
  output byte_t out_data,
  output logic  out_last,
  output logic  out_valid,
  input  logic  out_ready
);

  assign load_ready = !out_valid || out_ready;

  // Data and last only change on a load, so they stay stable while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= 8'h00;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_last  <= load_last;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_packet_demux.sv
// Routes one byte packet stream to one of NUM_OUTPUTS registered output streams,
// chosen by the address on the first beat; packets to missing outputs are counted and discarded.
module stream_packet_demux
  import stream_demux_pkg::*;
#(
  parameter  int NUM_OUTPUTS = 5,
  parameter  int DROP_CNT_W  = 16,
  localparam int ADDR_W      = $clog2(NUM_OUTPUTS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   in_data,
  input  logic [ADDR_W-1:0]            in_addr,
  input  logic                         in_last,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [NUM_OUTPUTS-1:0][7:0]  out_data,
  output logic [NUM_OUTPUTS-1:0]       out_last,
  output logic [NUM_OUTPUTS-1:0]       out_valid,
  input  logic [NUM_OUTPUTS-1:0]       out_ready,
  output logic [DROP_CNT_W-1:0]        drop_count
);

  localparam logic [ADDR_W:0] NUM_OUT_L = (ADDR_W + 1)'(NUM_OUTPUTS);

  demux_state_t            state, state_nxt;
  logic [ADDR_W-1:0]       dest_q;
  logic [ADDR_W-1:0]       dest;
  logic                    addr_ok;
  logic                    dropping;
  logic                    sel_ready;
  logic                    accept;
  logic                    first_drop;
  logic [NUM_OUTPUTS-1:0]  slice_ready;
  logic [NUM_OUTPUTS-1:0]  load;

  // With a power-of-two output count every address is in range.
  assign addr_ok    = {1'b0, in_addr} < NUM_OUT_L;
  assign accept     = in_valid && in_ready;
  assign first_drop = (state == IDLE) && accept && !addr_ok;

  always_comb begin
    dest     = dest_q;
    dropping = 1'b0;
    if (state == IDLE) begin
      dest     = in_addr;
      dropping = !addr_ok;
    end else if (state == DROP) begin
      dropping = 1'b1;
    end
  end

  // Only the selected output's slice can hold off the source.
  always_comb begin
    sel_ready = 1'b0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      if (dest == ADDR_W'(i)) sel_ready = slice_ready[i];
    end
    in_ready = dropping || sel_ready;
  end

  always_comb begin
    load = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      load[i] = accept && !dropping && (dest == ADDR_W'(i));
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && !in_last) state_nxt = addr_ok ? FWD : DROP;
      end
      FWD: begin
        if (accept && in_last) state_nxt = IDLE;
      end
      DROP: begin
        if (accept && in_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      dest_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && accept && addr_ok) dest_q <= in_addr;
    end
  end

  // Counts once per bad packet and sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
    end else if (first_drop && (drop_count != {DROP_CNT_W{1'b1}})) begin
      drop_count <= drop_count + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_out
    stream_reg_slice u_slice (
      .clk        (clk),
      .rst        (rst),
      .load       (load[i]),
      .load_data  (in_data),
      .load_last  (in_last),
      .load_ready (slice_ready[i]),
      .out_data   (out_data[i]),
      .out_last   (out_last[i]),
      .out_valid  (out_valid[i]),
      .out_ready  (out_ready[i])
    );
  end

endmodule
